fp_instr_encoder: RTL and testbench
===================================

// Module: fp_instr_encoder
// PURPOSE
//  Builds 32-bit RV32F instruction words from decoded command fields: FP op select, rm, rd/rs1/rs2/rs3, imm.
//  Round-trip partner of the FP instruction decoder. Used by the FP self-test sequencer and by the
//  verification stimulus path to generate decoder-legal FP instructions.
//  Commands enter on a valid/ready port and are encoded at acceptance. Encoded words pass through a small
//  FIFO and leave on a valid/ready port.
// PARAMETERS
//  DEPTH  4  output FIFO entries; power of two, >=2
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_ni         in   1      asynchronous active-low reset
//  flush_i        in   1      sync clear of FIFO, err_cnt_o untouched
//  cmd_valid_i    in   1      command valid
//  cmd_ready_o    out  1      command accept = cmd_valid_i & cmd_ready_o
//  cmd_op_i       in   5      op select, see BEHAVIOUR
//  cmd_rm_i       in   3      rounding mode for rm-carrying ops
//  cmd_rd_i       in   5      destination register
//  cmd_rs1_i      in   5      source register 1
//  cmd_rs2_i      in   5      source register 2
//  cmd_rs3_i      in   5      source register 3
//  cmd_imm_i      in   12     FLW/FSW offset
//  instr_valid_o  out  1      FIFO head valid
//  instr_ready_i  in   1      consumer takes head when valid&ready
//  instr_o        out  32     FIFO head instruction word
//  err_o          out  1      1-cycle pulse: accepted command was illegal
//  err_cnt_o      out  8      saturating count of illegal commands
//  fifo_level_o   out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset values: FIFO empty, instr_valid_o=0, instr_o=0, err_o=0, err_cnt_o=0, fifo_level_o=0.
//  cmd_ready_o = ~full & ~flush_i. There is no bypass. A push and a pop in the same cycle are allowed when not full.
//  Latency: command accepted in cycle N into an empty FIFO gives instr_valid_o=1 in cycle N+1.
//  instr_o/instr_valid_o stay stable while valid & ~ready.
//  flush_i: empties the FIFO next cycle; any pop in the same cycle is discarded.
//  Op codes:
//   0 FLW  op 07 f3 010 imm[11:0]->[31:20]
//   1 FSW  op 27 f3 010 imm[11:5]->[31:25] imm[4:0]->[11:7]
//   2 FMADD  op 43; 3 FMSUB  op 47; 4 FNMSUB op 4B; 5 FNMADD op 4F
//     R4 ops: rs3->[31:27], [26:25]=00, f3=rm
//  OP-FP ops (op 53), funct7 and f3/rs2 fixing:
//   6 FADD 0000000 / rm
//   7 FSUB 0000100 / rm
//   8 FMUL 0001000 / rm
//   9 FDIV 0001100 / rm
//   10 FSQRT 0101100 / rm, rs2=0
//   11/12/13 FSGNJ/N/X 0010000 / f3 000/001/010
//   14/15 FMIN/FMAX 0010100 / f3 000/001
//   16/17 FCVT.W.S/WU.S 1100000 / rm, rs2=0/1
//   18 FMV.X.W 1110000 / f3 000, rs2=0
//   19/20/21 FEQ/FLT/FLE 1010000 / f3 010/001/000
//   22 FCLASS 1110000 / f3 001, rs2=0
//   23/24 FCVT.S.W/S.WU 1101000 / rm, rs2=0/1
//   25 FMV.W.X 1111000 / f3 000, rs2=0
//  Unused fields are 0: rd for FSW, rs2 for FLW, rs3 for non-R4.
//  Illegal command: cmd_op_i>=26, or rm in {101,110} on an rm-carrying op (2-10,16,17,23,24).
//   Illegal commands are still accepted (ready rules unchanged), are not pushed, and pulse err_o next cycle.
//   err_cnt_o increments and saturates at 255.
//  Async reset mid-operation discards all FIFO contents immediately; no partial word is ever output.
//  Pointers wrap modulo DEPTH; full/empty via level counter.
// TESTING
//  FADD rd=3 rs1=1 rs2=2 rm=000 into empty FIFO, ready=1 -> next cycle instr_o=32'h002081D3, valid=1
//  FLW rd=5 rs1=10 imm=12'h004 -> 32'h00452287
//  FSW rs2=6 rs1=2 imm=12'h008 -> 32'h00612427
//  FMADD rd=1 rs1=2 rs2=3 rs3=4 rm=111 -> 32'h203170C3
//  FMV.X.W rd=7 rs1=8 -> 32'hE00403D3
//  Fill with ready=0 -> cmd_ready_o=0 at level DEPTH
//  Pop+push same cycle with ready=1 -> level unchanged
//  FADD rm=101, then op=31 -> two err_o pulses, err_cnt_o=2, level=0
//  flush_i with 3 queued -> level=0, valid=0 next cycle

Source files
------------

// File: rtl/fp_instr_encoder.sv
// fp_instr_encoder: encodes RV32F command fields into instruction words and queues them in a small FIFO.
module fp_instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [4:0]               cmd_op_i,
  input  logic [2:0]               cmd_rm_i,
  input  logic [4:0]               cmd_rd_i,
  input  logic [4:0]               cmd_rs1_i,
  input  logic [4:0]               cmd_rs2_i,
  input  logic [4:0]               cmd_rs3_i,
  input  logic [11:0]              cmd_imm_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [31:0]              instr_o,
  output logic                     err_o,
  output logic [7:0]               err_cnt_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [6:0]    f7;
  logic [2:0]    f3;
  logic [4:0]    r2;
  logic [31:0]   word;
  logic          rm_op, illegal, accept, push, pop;
  always_comb begin
    f7 = '0;
    f3 = cmd_rm_i;
    r2 = cmd_rs2_i;
    case (cmd_op_i)
      5'd7:  f7 = 7'h04;
      5'd8:  f7 = 7'h08;
      5'd9:  f7 = 7'h0C;
      5'd10: begin f7 = 7'h2C; r2 = 5'd0; end
      5'd11: begin f7 = 7'h10; f3 = 3'd0; end
      5'd12: begin f7 = 7'h10; f3 = 3'd1; end
      5'd13: begin f7 = 7'h10; f3 = 3'd2; end
      5'd14: begin f7 = 7'h14; f3 = 3'd0; end
      5'd15: begin f7 = 7'h14; f3 = 3'd1; end
      5'd16: begin f7 = 7'h60; r2 = 5'd0; end
      5'd17: begin f7 = 7'h60; r2 = 5'd1; end
      5'd18: begin f7 = 7'h70; f3 = 3'd0; r2 = 5'd0; end
      5'd19: begin f7 = 7'h50; f3 = 3'd2; end
      5'd20: begin f7 = 7'h50; f3 = 3'd1; end
      5'd21: begin f7 = 7'h50; f3 = 3'd0; end
      5'd22: begin f7 = 7'h70; f3 = 3'd1; r2 = 5'd0; end
      5'd23: begin f7 = 7'h68; r2 = 5'd0; end
      5'd24: begin f7 = 7'h68; r2 = 5'd1; end
      5'd25: begin f7 = 7'h78; f3 = 3'd0; r2 = 5'd0; end
      default: f7 = '0;
    endcase
    // R4 major opcodes 43/47/4B/4F differ only in bits [3:2]
    word = cmd_op_i == 5'd0 ? {cmd_imm_i, cmd_rs1_i, 3'b010, cmd_rd_i, 7'h07} :
           cmd_op_i == 5'd1 ? {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, 3'b010, cmd_imm_i[4:0], 7'h27} :
           cmd_op_i <= 5'd5 ? {cmd_rs3_i, 2'b00, cmd_rs2_i, cmd_rs1_i, cmd_rm_i, cmd_rd_i,
                               3'b100, cmd_op_i[1:0] ^ 2'b10, 2'b11} :
                              {f7, r2, cmd_rs1_i, f3, cmd_rd_i, 7'h53};
    rm_op   = (cmd_op_i >= 5'd2 && cmd_op_i <= 5'd10) || cmd_op_i == 5'd16 || cmd_op_i == 5'd17 ||
              cmd_op_i == 5'd23 || cmd_op_i == 5'd24;
    illegal = cmd_op_i >= 5'd26 || (rm_op && (cmd_rm_i == 3'b101 || cmd_rm_i == 3'b110));
  end
  assign cmd_ready_o   = fifo_level_o != (AW+1)'(DEPTH) && !flush_i;
  assign instr_valid_o = fifo_level_o != '0;
  assign instr_o       = instr_valid_o ? mem[rp] : '0;
  assign accept        = cmd_valid_i & cmd_ready_o;
  assign push          = accept & ~illegal;
  assign pop           = instr_valid_o & instr_ready_i & ~flush_i;
  always_ff @(posedge clk_i)
    if (push) mem[wp] <= word;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp           <= '0;
      rp           <= '0;
      fifo_level_o <= '0;
      err_o        <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      err_o <= accept & illegal;
      if (accept && illegal && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      if (flush_i) begin
        wp           <= '0;
        rp           <= '0;
        fifo_level_o <= '0;
      end else begin
        wp           <= wp + AW'(push);
        rp           <= rp + AW'(pop);
        fifo_level_o <= fifo_level_o + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
endmodule

// File: tb/tb_fp_instr_encoder.sv
// tb_fp_instr_encoder: directed and random checks of fp_instr_encoder against a reference encoder and scoreboard.
module tb_fp_instr_encoder;
  logic        clk = 0, rst_n = 0, flush = 0, cmd_valid = 0, cmd_ready;
  logic [4:0]  cmd_op = 0, cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0, cmd_rs3 = 0;
  logic [2:0]  cmd_rm = 0;
  logic [11:0] cmd_imm = 0;
  logic        instr_valid, instr_ready = 1, err;
  logic [31:0] instr;
  logic [7:0]  err_cnt;
  logic [2:0]  fifo_level;
  int          tests = 0, fails = 0, exp_cnt = 0;
  logic        exp_err = 0;
  logic [31:0] q[$];

  fp_instr_encoder #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_rm_i(cmd_rm), .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .cmd_rs3_i(cmd_rs3), .cmd_imm_i(cmd_imm), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .err_o(err), .err_cnt_o(err_cnt), .fifo_level_o(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // returns {legal, word}
  function automatic logic [32:0] model(input logic [4:0] op, input logic [2:0] rm,
      input logic [4:0] rd, rs1, rs2, rs3, input logic [11:0] imm);
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] r2;
    logic       rmo;
    f7 = 0; f3 = rm; r2 = rs2;
    rmo = (op inside {[2:10], 16, 17, 23, 24});
    if (op >= 26 || (rmo && (rm == 5 || rm == 6))) return {1'b0, 32'h0};
    case (op)
      0: return {1'b1, imm, rs1, 3'b010, rd, 7'h07};
      1: return {1'b1, imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h27};
      2: return {1'b1, rs3, 2'b00, rs2, rs1, rm, rd, 7'h43};
      3: return {1'b1, rs3, 2'b00, rs2, rs1, rm, rd, 7'h47};
      4: return {1'b1, rs3, 2'b00, rs2, rs1, rm, rd, 7'h4B};
      5: return {1'b1, rs3, 2'b00, rs2, rs1, rm, rd, 7'h4F};
      6: f7 = 7'b0000000;
      7: f7 = 7'b0000100;
      8: f7 = 7'b0001000;
      9: f7 = 7'b0001100;
      10: begin f7 = 7'b0101100; r2 = 0; end
      11, 12, 13: begin f7 = 7'b0010000; f3 = 3'(op - 11); end
      14, 15: begin f7 = 7'b0010100; f3 = 3'(op - 14); end
      16, 17: begin f7 = 7'b1100000; r2 = 5'(op - 16); end
      18: begin f7 = 7'b1110000; f3 = 0; r2 = 0; end
      19: begin f7 = 7'b1010000; f3 = 3'b010; end
      20: begin f7 = 7'b1010000; f3 = 3'b001; end
      21: begin f7 = 7'b1010000; f3 = 3'b000; end
      22: begin f7 = 7'b1110000; f3 = 3'b001; r2 = 0; end
      23, 24: begin f7 = 7'b1101000; r2 = 5'(op - 23); end
      default: begin f7 = 7'b1111000; f3 = 0; r2 = 0; end
    endcase
    return {1'b1, f7, r2, rs1, f3, rd, 7'h53};
  endfunction

  // scoreboard: compare pops, track level/err state, push expected words on acceptance
  always @(negedge clk) begin
    logic [32:0] m;
    if (!rst_n) begin
      q.delete();
      exp_err = 0;
      exp_cnt = 0;
    end else begin
      chk("level", 32'(fifo_level), 32'(q.size()));
      chk("err_o", 32'(err), 32'(exp_err));
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      if (instr_valid && instr_ready && !flush && q.size() > 0) chk("pop", instr, q.pop_front());
      m = model(cmd_op, cmd_rm, cmd_rd, cmd_rs1, cmd_rs2, cmd_rs3, cmd_imm);
      exp_err = cmd_valid && cmd_ready && !m[32];
      if (cmd_valid && cmd_ready && m[32]) q.push_back(m[31:0]);
      if (exp_err && exp_cnt != 255) exp_cnt++;
      if (flush) q.delete();
    end
  end

  task automatic send(input logic [4:0] op, input logic [2:0] rm, input logic [4:0] rd, rs1, rs2, rs3,
      input logic [11:0] imm);
    cmd_op = op; cmd_rm = rm; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rs3 = rs3; cmd_imm = imm;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    chk("rst_level", 32'(fifo_level), 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(cmd_ready), 1);
    send(6, 0, 3, 1, 2, 0, 0);
    chk("fadd", instr, 32'h002081D3);
    chk("fadd_valid", 32'(instr_valid), 1);
    send(0, 0, 5, 10, 0, 0, 12'h004);
    chk("flw", instr, 32'h00452287);
    chk("pushpop_level", 32'(fifo_level), 1);
    send(1, 0, 0, 2, 6, 0, 12'h008);
    chk("fsw", instr, 32'h00612427);
    send(2, 7, 1, 2, 3, 4, 0);
    chk("fmadd", instr, 32'h203170C3);
    send(18, 0, 7, 8, 0, 0, 0);
    chk("fmv_x_w", instr, 32'hE00403D3);
    @(posedge clk); #1;
    chk("drained", 32'(fifo_level), 0);
    instr_ready = 0;
    send(8, 1, 9, 10, 11, 0, 0);
    for (int i = 0; i < 3; i++) send(5'(6 + i), 3'(i), 5'(i), 5'(i + 1), 5'(i + 2), 0, 0);
    chk("full_ready", 32'(cmd_ready), 0);
    chk("full_level", 32'(fifo_level), 4);
    cmd_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 0;
    chk("stall_head", instr, 32'h10B514D3);
    chk("stall_level", 32'(fifo_level), 4);
    instr_ready = 1;
    @(posedge clk); #1;
    send(11, 0, 1, 2, 3, 0, 0);
    chk("pushpop_level3", 32'(fifo_level), 3);
    instr_ready = 0;
    flush = 1;
    #1;
    chk("flush_ready", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    flush = 0;
    chk("flush_level", 32'(fifo_level), 0);
    chk("flush_valid", 32'(instr_valid), 0);
    instr_ready = 1;
    send(6, 3'b101, 1, 2, 3, 0, 0);
    chk("err1", 32'(err), 1);
    @(posedge clk); #1;
    chk("err1_pulse", 32'(err), 0);
    send(31, 0, 1, 2, 3, 0, 0);
    chk("err2", 32'(err), 1);
    chk("err2_cnt", 32'(err_cnt), 2);
    chk("err2_level", 32'(fifo_level), 0);
    for (int i = 0; i < 300; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 5'($urandom_range(0, 27));
      cmd_rm = 3'($urandom_range(0, 7));
      cmd_rd = 5'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom); cmd_rs3 = 5'($urandom);
      cmd_imm = 12'($urandom);
      instr_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      @(posedge clk); #1;
    end
    flush = 0;
    instr_ready = 1;
    cmd_op = 31;
    cmd_valid = 1;
    repeat (260) @(posedge clk);
    #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("sat_cnt", 32'(err_cnt), 255);
    instr_ready = 0;
    send(7, 2, 4, 5, 6, 0, 0);
    send(12, 0, 7, 8, 9, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_instr", instr, 0);
    chk("arst_cnt", 32'(err_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1;
    instr_ready = 1;
    @(posedge clk); #1;
    send(6, 0, 3, 1, 2, 0, 0);
    chk("post_rst_fadd", instr, 32'h002081D3);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
